// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - Load-type codes, identical to the MEM-stage memory unit encoding.
//   - FSM state encoding.
//   - Byte-enable value used by the memory unit to flag a misaligned store.
//   - Latched request record and the load-legality helper.
package dmem_pkg;

    localparam logic [2:0] LT_LB   = 3'b000;
    localparam logic [2:0] LT_LH   = 3'b001;
    localparam logic [2:0] LT_LW   = 3'b010;
    localparam logic [2:0] LT_LBU  = 3'b100;
    localparam logic [2:0] LT_LHU  = 3'b101;
    localparam logic [2:0] LT_NONE = 3'b111;

    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Snapshot of the request taken at acceptance; the bus may change freely
    // afterwards without affecting the access in flight.
    typedef struct packed {
        logic        is_store;
        logic        both;      // store and load requested together
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [2:0]  lt;
    } req_t;

    // True when a load of the given type cannot be served at this lane.
    // Unknown encodings and LT_NONE are never legal loads.
    function automatic logic load_illegal(logic [2:0] lt, logic [1:0] lane);
        case (lt)
            LT_LB, LT_LBU: return 1'b0;
            LT_LH, LT_LHU: return lane[0];
            LT_LW:         return lane != 2'b00;
            LT_NONE:       return 1'b1;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory bus between the MEM-stage memory unit (master) and the
// responder (slave).
//   Requests : wr_enable, read_enable, wr_addr, read_addr, wr_data,
//              write_byte_enable, load_type
//   Responses: rdata, rdata_valid, busy, err, err_addr
interface dmem_if;

    logic        wr_enable;
    logic        read_enable;
    logic [31:0] wr_addr;
    logic [31:0] read_addr;
    logic [31:0] wr_data;
    logic [3:0]  write_byte_enable;
    logic [2:0]  load_type;

    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        err;
    logic [31:0] err_addr;

    modport master (
        output wr_enable, read_enable, wr_addr, read_addr, wr_data,
               write_byte_enable, load_type,
        input  rdata, rdata_valid, busy, err, err_addr
    );

    modport slave (
        input  wr_enable, read_enable, wr_addr, read_addr, wr_data,
               write_byte_enable, load_type,
        output rdata, rdata_valid, busy, err, err_addr
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the right-justified pipeline view and the
// word-organised RAM.
//   st_data/st_be  in : right-justified store data and enables
//   lane           in : byte offset within the word (addr[1:0])
//   ld_word        in : RAM word addressed by the load
//   load_type      in : load-type code
//   st_data_sh     out: store data moved to its lane
//   st_be_sh       out: store enables moved to its lane
//   ld_data        out: extracted and sign/zero-extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    input  logic [1:0]  lane,
    input  logic [31:0] ld_word,
    input  logic [2:0]  load_type,
    output logic [31:0] st_data_sh,
    output logic [3:0]  st_be_sh,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_data_sh = st_data << {lane, 3'b000};
        // Enables that would fall past byte 3 are dropped; the memory unit
        // never issues such a store with non-zero enables.
        st_be_sh   = st_be << lane;

        ld_byte    = 8'(ld_word >> {lane, 3'b000});
        ld_half    = lane[1] ? ld_word[31:16] : ld_word[15:0];

        case (load_type)
            LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {24'h0, ld_byte};
            LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the data-memory interface. Accepts one-cycle store strobes
// and held load requests, inserts WAIT_CYCLES wait states (raising busy while
// the access is pending), then commits in a single DONE cycle: byte-enabled
// store into the RAM or an extended load registered into rdata. Illegal
// accesses are suppressed and reported through err / err_addr.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_if slave (request inputs, rdata/rdata_valid/busy/err/
//              err_addr outputs)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);

    state_e      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        req, accept, busy_c;
    req_t        cur;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ld_word;

    logic [32:0] off;
    logic        in_range, bad, do_store, do_load;
    logic [AW-1:0] widx;

    logic [31:0] st_data_sh, ld_data;
    logic [3:0]  st_be_sh;

    logic [31:0] rdata_q, err_addr_q;
    logic        rdata_valid_q, err_q;

    assign req = bus.wr_enable | bus.read_enable;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_c   = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                        busy_c   = 1'b1;   // stall from the request cycle on
                    end
                end
            end
            WAIT: begin
                busy_c = 1'b1;
                if (cnt == 4'd0) state_nx = DONE;
                else             cnt_nx   = cnt - 4'd1;
            end
            // busy stays low here so the pipeline advances in the commit
            // cycle; any request seen now belongs to the same instruction.
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- request capture ----------------
    // A store wins the address mux when both enables are up; the load is
    // dropped and flagged as an error at commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (accept) begin
            cur.is_store <= bus.wr_enable;
            cur.both     <= bus.wr_enable & bus.read_enable;
            cur.addr     <= bus.wr_enable ? bus.wr_addr : bus.read_addr;
            cur.data     <= bus.wr_data;
            cur.be       <= bus.write_byte_enable;
            cur.lt       <= bus.load_type;
        end
    end

    // ---------------- decode ----------------
    // 33-bit offset: an address below BASE_ADDR wraps to >= 2^32 and so also
    // fails the upper-bound compare.
    assign off      = {1'b0, cur.addr} - {1'b0, BASE_ADDR};
    assign in_range = !off[32] && (off < SPAN);
    assign widx     = off[AW+1:2];

    assign bad = !in_range | cur.both |
                 (cur.is_store ? (cur.be == BE_NONE)
                               : load_illegal(cur.lt, cur.addr[1:0]));

    // The store half of a simultaneous store+load still commits.
    assign do_store = (state == DONE) && cur.is_store && in_range && (cur.be != BE_NONE);
    assign do_load  = (state == DONE) && !cur.is_store && !bad;

    assign ld_word = mem[widx];

    dmem_lane_align u_align (
        .st_data    (cur.data),
        .st_be      (cur.be),
        .lane       (cur.addr[1:0]),
        .ld_word    (ld_word),
        .load_type  (cur.lt),
        .st_data_sh (st_data_sh),
        .st_be_sh   (st_be_sh),
        .ld_data    (ld_data)
    );

    // ---------------- RAM (contents not reset) ----------------
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be_sh[b]) mem[widx][8*b +: 8] <= st_data_sh[8*b +: 8];
            end
        end
    end

    // ---------------- responses ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= 32'h0;
        end else begin
            rdata_valid_q <= do_load;
            err_q         <= 1'b0;
            if (do_load) rdata_q <= ld_data;
            if (state == DONE && bad) begin
                err_q      <= 1'b1;
                err_addr_q <= cur.addr;
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.busy        = busy_c;
    assign bus.err         = err_q;
    assign bus.err_addr    = err_addr_q;

endmodule
